bist_prpg_misr: RTL
===================

# bist_prpg_misr

Parametrised built-in self-test register for the scan test path: one NBIT-wide Fibonacci shift register that works as a pseudo-random pattern generator (PRPG), a multiple-input signature register (MISR) or a plain scan segment. A small controller runs a programmed number of steps and compares the final state against a golden signature. It replaces the fixed 4-bit scan LFSR as the pattern source and response compactor in the BIST wrapper.

## Interface
- NBIT, 8: register width, ≥ 3.
- POLY, 8'hB8: feedback tap mask; bit i set means s[i] feeds the XOR.
- SEED, {NBIT{1'b1}}: value loaded by reset and by init.
- CNT_W, 16: width of the step counter.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  00 hold, 01 PRPG, 10 MISR, 11 scan.
- start  in  1  begin a run; PRPG/MISR only.
- init  in  1  reload SEED; honoured in IDLE/DONE only.
- npat  in  CNT_W  number of steps for the run.
- scan_in  in  1  serial input in scan mode.
- data_in  in  NBIT  response word compacted in MISR mode.
- golden_sig  in  NBIT  expected final signature.
- out  out  NBIT  current register state s.
- scan_out  out  1  s[NBIT-1].
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  done && (out == golden_sig), combinational.

## Operation
- Feedback: fb = ^(s & POLY).
- PRPG step: s <= {s[NBIT-2:0], fb}.
- MISR step: s <= {s[NBIT-2:0], fb} ^ data_in.
- Scan step: s <= {s[NBIT-2:0], scan_in}.
- FSM states: IDLE, RUN, DONE.
- IDLE: mode 11 shifts one scan step per cycle. Modes 00, 01 and 10 hold s. init=1 loads SEED and overrides scan.
- IDLE/DONE with start=1 and mode ∈ {01,10}: latch the mode, load cnt=npat, clear done. Go to RUN if npat≠0, otherwise go to DONE. start with mode 00/11 is ignored.
- start and init asserted together: init wins and start is ignored.
- RUN: one step per cycle in the latched mode; mode, start and init inputs are ignored. cnt decrements on each step; the step taken with cnt==1 moves the FSM to DONE.
- DONE: s holds. Leave on start (new run, continues from current s) or init (load SEED, go to IDLE). A scan request in DONE is ignored.
- Counter arithmetic is unsigned and never wraps; maximum run length is 2^CNT_W−1.
- Reset values: s=SEED, out=SEED, scan_out=SEED[NBIT-1], busy=0, done=0, pass=0, cnt=0, FSM=IDLE.
- Reset mid-run aborts immediately with the same values; no partial signature is kept.

## Timing
- start accepted at edge k: steps occur at edges k+1 … k+npat. busy is high from after edge k until edge k+npat; done rises after edge k+npat.
- npat=0: done is high after edge k; busy never asserts; s is unchanged.
- data_in is sampled at every RUN edge in MISR mode: exactly npat words.
- Scan: scan_out shows s[NBIT-1] before the edge, so one bit appears per cycle with zero added latency.
- pass is valid in the same cycle as done and follows golden_sig combinationally.

## Configuration
- PRPG_LOCKUP_RECOVER_EN defined: a PRPG step taken when s==0 loads SEED instead of shifting. This escapes the all-zero lock-up state that MISR or scan can leave behind.
- Undefined: all-zero state stays all-zero under PRPG steps. MISR and scan behaviour are identical in both builds.

## Test plan
All scenarios use NBIT=4, POLY=4'b1100, SEED=4'b1111.
- PRPG, npat=4 → out goes 1110, 1100, 1000, 0001 on successive cycles; busy high for 4 cycles; done with out=0001.
- PRPG, npat=15 → out passes through all 15 non-zero states and returns to 1111 with done=1; golden_sig=1111 gives pass=1.
- npat=0 → done=1 one cycle after start, busy never high, out=1111.
- MISR, data_in=0011, npat=2 → out goes 1101 then 1001. golden_sig=1001 gives pass=1; golden_sig=1000 gives pass=0.
- Scan mode in IDLE, scan_in 0,0,0,0 → out goes 1110, 1100, 1000, 0000; scan_out reads 1,1,1,1. Then PRPG npat=3: with the macro defined, out goes 1111, 1110, 1100; without it, out stays 0000.
- Reset asserted on the 2nd cycle of a PRPG run with npat=10 → next cycle out=1111, busy=0, done=0; a following start runs normally.

Source files
------------

// File: rtl/bist_prpg_misr_if.sv
// Bus between the BIST controller and the PRPG/MISR register: run control,
// serial scan, response data and signature status.
interface bist_prpg_misr_if #(
  parameter int NBIT  = 8,
  parameter int CNT_W = 16
);
  logic [1:0]       mode;
  logic             start;
  logic             init;
  logic [CNT_W-1:0] npat;
  logic             scan_in;
  logic [NBIT-1:0]  data_in;
  logic [NBIT-1:0]  golden_sig;
  logic [NBIT-1:0]  out;
  logic             scan_out;
  logic             busy;
  logic             done;
  logic             pass;

  modport master (
    output mode, start, init, npat, scan_in, data_in, golden_sig,
    input  out, scan_out, busy, done, pass
  );

  modport slave (
    input  mode, start, init, npat, scan_in, data_in, golden_sig,
    output out, scan_out, busy, done, pass
  );
endinterface

// File: rtl/bist_prpg_misr.sv
// Fibonacci shift register shared as PRPG, MISR and scan segment, with a run
// controller. Optional PRPG_LOCKUP_RECOVER_EN reseeds on a PRPG step from all-zero.
module bist_prpg_misr #(
  parameter int              NBIT  = 8,
  parameter logic [NBIT-1:0] POLY  = 8'hB8,
  parameter logic [NBIT-1:0] SEED  = {NBIT{1'b1}},
  parameter int              CNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  bist_prpg_misr_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] MODE_PRPG = 2'b01;
  localparam logic [1:0] MODE_MISR = 2'b10;
  localparam logic [1:0] MODE_SCAN = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [NBIT-1:0]  s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             misr_q, misr_d;

  logic             fb;
  logic [NBIT-1:0]  shift_fb;
  logic [NBIT-1:0]  prpg_nxt;
  logic [NBIT-1:0]  misr_nxt;
  logic [NBIT-1:0]  scan_nxt;
  logic             start_ok;

  always_comb begin
    fb       = ^(s_q & POLY);
    shift_fb = {s_q[NBIT-2:0], fb};
`ifdef PRPG_LOCKUP_RECOVER_EN
    prpg_nxt = (s_q == '0) ? SEED : shift_fb;
`else
    prpg_nxt = shift_fb;
`endif
    misr_nxt = shift_fb ^ bus.data_in;
    scan_nxt = {s_q[NBIT-2:0], bus.scan_in};
    start_ok = bus.start && (bus.mode == MODE_PRPG || bus.mode == MODE_MISR);
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    misr_d  = misr_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // init has priority over both start and scan
        if (bus.init) begin
          s_d     = SEED;
          state_d = ST_IDLE;
        end else if (start_ok) begin
          misr_d  = (bus.mode == MODE_MISR);
          cnt_d   = bus.npat;
          state_d = (bus.npat != '0) ? ST_RUN : ST_DONE;
        end else if (state_q == ST_IDLE && bus.mode == MODE_SCAN) begin
          s_d = scan_nxt;
        end
      end
      ST_RUN: begin
        s_d   = misr_q ? misr_nxt : prpg_nxt;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      s_q     <= SEED;
      cnt_q   <= '0;
      misr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      misr_q  <= misr_d;
    end
  end

  assign bus.out      = s_q;
  assign bus.scan_out = s_q[NBIT-1];
  assign bus.busy     = (state_q == ST_RUN);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.pass     = (state_q == ST_DONE) && (s_q == bus.golden_sig);

endmodule
